// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver control path.
//   rx_state_e          : FSM state encoding
//   START_IDX..PAR_IDX  : bit indices within a frame as seen on BIT_CNT
//   PAR_EVEN / PAR_ODD  : encodings of the PAR_TYP input
//   par_error()         : parity check of a received parity bit
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic [3:0] START_IDX  = 4'd0;
    localparam logic [3:0] DATA_FIRST = 4'd1;
    localparam logic [3:0] DATA_LAST  = 4'd8;
    localparam logic [3:0] PAR_IDX    = 4'd9;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // run_par is the XOR of the eight data bits. Even parity expects the
    // parity bit to equal it, odd parity expects its complement.
    function automatic logic par_error(input logic samp,
                                       input logic run_par,
                                       input logic par_typ);
        logic exp_bit;
        exp_bit = (par_typ == PAR_ODD) ? ~run_par : run_par;
        return samp != exp_bit;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and frame bit counter for the UART receiver.
// Ports:
//   CLK, RST  : clock, asynchronous active-high reset
//   ENABLE    : counting enable (FSM outside IDLE); counters held at 0 when low
//   CLEAR     : synchronous clear, used when the FSM returns to IDLE
//   PRESCALE  : oversampling ratio (8, 16 or 32)
//   EDGE_CNT  : edge index within the current bit, 0..PRESCALE-1
//   BIT_CNT   : bit index within the frame
//   BIT_END   : high on the last oversample edge of a bit
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic                  CLEAR,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic [PRESCALE_W-1:0] EDGE_CNT,
    output logic [3:0]            BIT_CNT,
    output logic                  BIT_END
);

    logic [PRESCALE_W-1:0] last_edge;

    // The compare stays at PRESCALE_W bits so PRESCALE=32 fits a 6-bit field.
    assign last_edge = PRESCALE - PRESCALE_W'(1);
    assign BIT_END   = ENABLE && (EDGE_CNT == last_edge);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            EDGE_CNT <= '0;
            BIT_CNT  <= START_IDX;
        end else if (!ENABLE || CLEAR) begin
            EDGE_CNT <= '0;
            BIT_CNT  <= START_IDX;
        end else if (BIT_END) begin
            EDGE_CNT <= '0;
            BIT_CNT  <= BIT_CNT + 4'd1;
        end else begin
            // If PRESCALE changes mid-frame the count may pass last_edge; it
            // then wraps through zero and meets last_edge again, so no lock-up.
            EDGE_CNT <= EDGE_CNT + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// Control FSM of the UART receiver: start-bit detection, bit timing,
// sampler/deserializer enables and in-line start/parity/stop checking.
// Ports:
//   CLK, RST     : clock, asynchronous active-high reset
//   RX_IN        : synchronised serial line, idles high
//   PAR_EN       : parity bit present
//   PAR_TYP      : 0 even, 1 odd parity
//   PRESCALE     : oversampling ratio (8, 16, 32)
//   SAMPLED_BIT  : majority-voted bit, valid at EDGE_CNT == PRESCALE-1
//   EDGE_CNT     : oversample edge index within the current bit
//   BIT_CNT      : bit index in frame (0 start, 1-8 data, 9 parity/stop, 10 stop)
//   DAT_SAMP_EN  : sampler enable (any state but IDLE)
//   DESER_EN     : deserializer enable (DATA state)
//   DATA_VALID   : one-cycle pulse after a clean frame
//   PAR_ERR      : parity error of the last frame
//   STP_ERR      : stop-bit error of the last frame
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  SAMPLED_BIT,
    output logic [PRESCALE_W-1:0] EDGE_CNT,
    output logic [3:0]            BIT_CNT,
    output logic                  DAT_SAMP_EN,
    output logic                  DESER_EN,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    rx_state_e state, state_nxt;
    logic      run_par, run_par_nxt;
    logic      par_err_nxt;
    logic      stp_err_nxt;
    logic      data_valid_nxt;
    logic      frame_clr;
    logic      bit_end;

    assign DAT_SAMP_EN = (state != IDLE);
    assign DESER_EN    = (state == DATA);

    uart_rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W)
    ) u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .ENABLE   (DAT_SAMP_EN),
        .CLEAR    (frame_clr),
        .PRESCALE (PRESCALE),
        .EDGE_CNT (EDGE_CNT),
        .BIT_CNT  (BIT_CNT),
        .BIT_END  (bit_end)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            run_par    <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            DATA_VALID <= 1'b0;
        end else begin
            state      <= state_nxt;
            run_par    <= run_par_nxt;
            PAR_ERR    <= par_err_nxt;
            STP_ERR    <= stp_err_nxt;
            DATA_VALID <= data_valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        run_par_nxt    = run_par;
        par_err_nxt    = PAR_ERR;
        stp_err_nxt    = STP_ERR;
        data_valid_nxt = 1'b0;
        frame_clr      = 1'b0;

        case (state)
            IDLE: begin
                // Flags of the previous frame are held until a new start bit.
                if (!RX_IN) begin
                    state_nxt   = START;
                    run_par_nxt = 1'b0;
                    par_err_nxt = 1'b0;
                    stp_err_nxt = 1'b0;
                end
            end

            START: begin
                if (bit_end) begin
                    // A start bit that reads back high was line noise.
                    if (SAMPLED_BIT) begin
                        state_nxt = IDLE;
                        frame_clr = 1'b1;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end

            DATA: begin
                if (bit_end) begin
                    run_par_nxt = run_par ^ SAMPLED_BIT;
                    if (BIT_CNT == DATA_LAST) begin
                        state_nxt = PAR_EN ? PARITY : STOP;
                    end
                end
            end

            PARITY: begin
                if (bit_end) begin
                    par_err_nxt = par_error(SAMPLED_BIT, run_par, PAR_TYP);
                    state_nxt   = STOP;
                end
            end

            STOP: begin
                if (bit_end) begin
                    stp_err_nxt    = ~SAMPLED_BIT;
                    data_valid_nxt = ~par_err_nxt & SAMPLED_BIT;
                    state_nxt      = IDLE;
                    frame_clr      = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                frame_clr = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm. The driver pushes one expectation per
// frame it sends; the monitor tracks each busy period (DAT_SAMP_EN high)
// and checks it against the popped expectation when the FSM falls back to
// IDLE. A one-cycle delayed copy of RX_IN stands in for the data sampler.
module tb_uart_rx_fsm;

    typedef struct {
        logic v;        // DATA_VALID expected
        logic pe;       // PAR_ERR expected
        logic se;       // STP_ERR expected
        int   len;      // busy cycles, -1 = aborted frame (not checked)
        int   deser;    // DESER_EN cycles
        int   maxbit;   // highest BIT_CNT seen
        int   maxedge;  // highest EDGE_CNT seen
        int   gap;      // cycles since previous DATA_VALID, -1 = not checked
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       par_en;
    logic       par_typ;
    logic [5:0] prescale;
    logic       samp = 1'b1;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       deser_en;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    int cyc = 0;
    int last_dv = 0;
    int cnt_en, cnt_deser, max_bit, max_edge, idx;

    always #5 clk = ~clk;

    // Stand-in sampler: the value on the line one edge before the bit end.
    always @(posedge clk) samp <= rx_in;

    uart_rx_fsm #(
        .PRESCALE_W (6)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .RX_IN       (rx_in),
        .PAR_EN      (par_en),
        .PAR_TYP     (par_typ),
        .PRESCALE    (prescale),
        .SAMPLED_BIT (samp),
        .EDGE_CNT    (edge_cnt),
        .BIT_CNT     (bit_cnt),
        .DAT_SAMP_EN (dat_samp_en),
        .DESER_EN    (deser_en),
        .DATA_VALID  (data_valid),
        .PAR_ERR     (par_err),
        .STP_ERR     (stp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic pe, input logic se,
                                input int len, input int deser, input int maxbit,
                                input int maxedge, input int gap);
        exp_t e;
        e.v = v; e.pe = pe; e.se = se; e.len = len; e.deser = deser;
        e.maxbit = maxbit; e.maxedge = maxedge; e.gap = gap;
        return e;
    endfunction

    task automatic drive_bit(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Start, 8 data bits LSB first, optional parity, stop, then one extra
    // high cycle so a following frame starts in the DATA_VALID cycle.
    task automatic send_frame(input logic [7:0] d, input logic pbit,
                              input logic sbit, input exp_t e);
        int p;
        p = int'(prescale);
        sb.push_back(e);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (par_en) drive_bit(pbit, p);
        drive_bit(sbit, p);
        drive_bit(1'b1, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_edge_cnt"}, 32'(edge_cnt), 0);
        chk({tag, "_bit_cnt"}, 32'(bit_cnt), 0);
        chk({tag, "_samp_en"}, 32'(dat_samp_en), 0);
        chk({tag, "_deser_en"}, 32'(deser_en), 0);
        chk({tag, "_data_valid"}, 32'(data_valid), 0);
        chk({tag, "_par_err"}, 32'(par_err), 0);
        chk({tag, "_stp_err"}, 32'(stp_err), 0);
    endtask

    // Monitor
    initial begin : monitor
        exp_t e;
        logic prev;
        logic falling;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            falling = prev && !dat_samp_en;
            if (dat_samp_en) begin
                if (!prev) begin
                    cnt_en = 0; cnt_deser = 0; max_bit = 0; max_edge = 0; idx = 1;
                    chk("start_clears_par_err", 32'(par_err), 0);
                    chk("start_clears_stp_err", 32'(stp_err), 0);
                end
                cnt_en++;
                if (deser_en) cnt_deser++;
                if (int'(bit_cnt) > max_bit) max_bit = int'(bit_cnt);
                if (int'(edge_cnt) > max_edge) max_edge = int'(edge_cnt);
                if (deser_en && edge_cnt == prescale - 6'd1) begin
                    chk("bit_cnt_at_bit_end", 32'(bit_cnt), 32'(idx));
                    idx++;
                end
            end else if (falling) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_end: no frame expected, got dv=%0b (t=%0t)", data_valid, $time);
                end else begin
                    e = sb.pop_front();
                    chk("data_valid", 32'(data_valid), 32'(e.v));
                    chk("par_err", 32'(par_err), 32'(e.pe));
                    chk("stp_err", 32'(stp_err), 32'(e.se));
                    if (e.len >= 0) begin
                        chk("busy_cycles", 32'(cnt_en), 32'(e.len));
                        chk("deser_cycles", 32'(cnt_deser), 32'(e.deser));
                        chk("max_bit_cnt", 32'(max_bit), 32'(e.maxbit));
                        chk("max_edge_cnt", 32'(max_edge), 32'(e.maxedge));
                    end
                    if (data_valid && e.gap >= 0)
                        chk("dv_spacing", 32'(cyc - last_dv), 32'(e.gap));
                end
                if (data_valid) last_dv = cyc;
            end
            if (data_valid && !falling) chk("spurious_data_valid", 32'(data_valid), 0);
            prev = dat_samp_en;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

    // Stimulus
    initial begin : driver
        rst      = 1'b1;
        rx_in    = 1'b1;
        par_en   = 1'b1;
        par_typ  = 1'b0;
        prescale = 6'd8;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        drive_bit(1'b1, 5);

        // Reset in the middle of DATA aborts the frame.
        sb.push_back(mk(1'b0, 1'b0, 1'b0, -1, 0, 0, 0, -1));
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        rx_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive_bit(1'b1, 10);
        // Frame after the abort is received normally.
        send_frame(8'hA5, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 88, 64, 10, 7, -1));
        drive_bit(1'b1, 10);

        // 0xA5 even parity, correct parity bit.
        send_frame(8'hA5, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 88, 64, 10, 7, -1));
        drive_bit(1'b1, 10);

        // Same frame, wrong parity bit; flag must hold in IDLE.
        send_frame(8'hA5, 1'b1, 1'b1, mk(1'b0, 1'b1, 1'b0, 88, 64, 10, 7, -1));
        drive_bit(1'b1, 20);
        chk("par_err_hold", 32'(par_err), 1);
        chk("stp_err_hold_clean", 32'(stp_err), 0);

        // No parity, bad stop bit.
        par_en = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b1, 80, 64, 9, 7, -1));
        drive_bit(1'b1, 20);
        chk("stp_err_hold", 32'(stp_err), 1);

        // Start-bit glitch.
        par_en = 1'b1;
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 8, 0, 0, 7, -1));
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 20);

        // Back-to-back at PRESCALE 16, no parity.
        par_en   = 1'b0;
        prescale = 6'd16;
        send_frame(8'h00, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 160, 128, 9, 15, -1));
        send_frame(8'hFF, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 160, 128, 9, 15, 161));
        drive_bit(1'b1, 20);

        // Odd parity at PRESCALE 32: 0x01 has one set bit, parity bit 0.
        par_en   = 1'b1;
        par_typ  = 1'b1;
        prescale = 6'd32;
        send_frame(8'h01, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 352, 256, 10, 31, -1));
        drive_bit(1'b1, 10);

        // Odd parity at PRESCALE 8: 0x03 has two set bits, parity bit 0 is wrong.
        prescale = 6'd8;
        send_frame(8'h03, 1'b0, 1'b1, mk(1'b0, 1'b1, 1'b0, 88, 64, 10, 7, -1));
        drive_bit(1'b1, 20);

        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
